// File: rtl/booth_seq_mul_if.sv
// Operand/result handshake bundle for the sequential radix-4 Booth multiplier.
interface booth_seq_mul_if #(
    parameter int N = 16
);
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   a_i;
    logic [N-1:0]   b_i;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-1:0] product_o;
    logic           busy_o;

    modport master (
        output in_valid, a_i, b_i, out_ready,
        input  in_ready, out_valid, product_o, busy_o
    );

    modport slave (
        input  in_valid, a_i, b_i, out_ready,
        output in_ready, out_valid, product_o, busy_o
    );
endinterface

// File: rtl/booth_seq_mul.sv
// Sequential radix-4 Booth multiplier: one shared carry-select adder, N/2 steps per signed NxN product.
module booth_seq_mul #(
    parameter int N     = 16,
    parameter int RCA_W = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    booth_seq_mul_if.slave  bus
);
    localparam int W  = N + 2;
    localparam int CW = $clog2(N / 2 + 1);
    localparam int NB = (W + RCA_W - 1) / RCA_W;
    localparam logic [CW-1:0] LAST_CNT = CW'(N / 2 - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   mcand_q, mcand_d;
    logic [W-1:0]   acc_q, acc_d;
    logic [N-1:0]   q_q, q_d;
    logic           qm1_q, qm1_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           in_ready_q, in_ready_d;
    logic           out_valid_q, out_valid_d;
    logic           busy_q, busy_d;
    logic [2*N-1:0] product_q, product_d;

    logic [W-1:0]   m_ext, pp, csa_b, csa_sum;
    logic           csa_cin;
    logic [W+N-1:0] step_cat;
    logic [W-1:0]   acc_next;
    logic [N-1:0]   q_next;

    // Booth digit recoding: select 0, +-M or +-2M; negation is ~pp with carry-in 1.
    always_comb begin
        m_ext   = {{2{mcand_q[N-1]}}, mcand_q};
        pp      = '0;
        csa_cin = 1'b0;
        unique case ({q_q[1:0], qm1_q})
            3'b001, 3'b010: pp = m_ext;
            3'b011:         pp = m_ext << 1;
            3'b100: begin
                pp      = m_ext << 1;
                csa_cin = 1'b1;
            end
            3'b101, 3'b110: begin
                pp      = m_ext;
                csa_cin = 1'b1;
            end
            default:        pp = '0;
        endcase
        csa_b = csa_cin ? ~pp : pp;
    end

    // Carry-select adder; the top block produces no carry-out since it is never consumed.
    logic [NB-1:0] blk_c;
    assign blk_c[0] = csa_cin;

    for (genvar g = 0; g < NB; g++) begin : g_blk
        localparam int LO = g * RCA_W;
        localparam int BW = (W - LO < RCA_W) ? (W - LO) : RCA_W;
        localparam int EW = (g == NB - 1) ? BW : BW + 1;
        logic [EW-1:0] s0, s1;
        assign s0 = EW'(acc_q[LO +: BW]) + EW'(csa_b[LO +: BW]);
        assign s1 = s0 + EW'(1);
        assign csa_sum[LO +: BW] = blk_c[g] ? s1[BW-1:0] : s0[BW-1:0];
        if (g < NB - 1) begin : g_carry
            assign blk_c[g+1] = blk_c[g] ? s1[BW] : s0[BW];
        end
    end

    always_comb begin
        step_cat = $unsigned($signed({csa_sum, q_q}) >>> 2);
        acc_next = step_cat[W+N-1:N];
        q_next   = step_cat[N-1:0];
    end

    always_comb begin
        state_d     = state_q;
        mcand_d     = mcand_q;
        acc_d       = acc_q;
        q_d         = q_q;
        qm1_d       = qm1_q;
        cnt_d       = cnt_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        product_d   = product_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    state_d    = CALC;
                    mcand_d    = bus.a_i;
                    q_d        = bus.b_i;
                    acc_d      = '0;
                    qm1_d      = 1'b0;
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            CALC: begin
                acc_d = acc_next;
                q_d   = q_next;
                qm1_d = q_q[1];
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d     = DONE;
                    busy_d      = 1'b0;
                    out_valid_d = 1'b1;
                    product_d   = {acc_next[N-1:0], q_next};
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    product_d   = '0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
                product_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mcand_q     <= '0;
            acc_q       <= '0;
            q_q         <= '0;
            qm1_q       <= 1'b0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            product_q   <= '0;
        end else begin
            state_q     <= state_d;
            mcand_q     <= mcand_d;
            acc_q       <= acc_d;
            q_q         <= q_d;
            qm1_q       <= qm1_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            product_q   <= product_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy_o    = busy_q;
    assign bus.product_o = product_q;
endmodule
